// File: rtl/mii_phy_pkg.sv
// Shared types and constants for the MII receive-side nibble generator.
package mii_phy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    DROP,
    FCS,
    IFG
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational reflected CRC-32 update over one byte, LSB of the byte first.
module eth_crc32_byte
  import mii_phy_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  always_comb begin
    crc_next = crc;
    for (int i = 0; i < 8; i++) begin
      if (crc_next[0] ^ data[i]) crc_next = (crc_next >> 1) ^ CRC_POLY;
      else                       crc_next = crc_next >> 1;
    end
  end

endmodule

// File: rtl/mii_phy_rx_gen.sv
// AXI-stream byte frames to MII receive nibbles with preamble, SFD and gap.
// Define MII_PHY_RX_GEN_FCS_EN to append a generated CRC-32 FCS after the payload.
module mii_phy_rx_gen
  import mii_phy_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_NIBBLES  = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [3:0] mii_rxd,
  output logic       mii_rx_dv,
  output logic       mii_rx_er,
  output logic       busy,
  output logic       underflow,
  output state_t     state
);

  // A byte transfers on a rising edge where tvalid and tready are both high;
  // tready is registered, so it already reflects whether this cycle may accept.

  localparam logic [4:0] PRE_LOAD = 5'(2 * PREAMBLE_LEN - 1);
  localparam logic [7:0] IFG_LOAD = 8'(IFG_NIBBLES - 1);

  state_t     state_n;
  logic       half, half_n;
  logic [4:0] pcnt, pcnt_n;
  logic [7:0] icnt, icnt_n;
  logic [7:0] data_q, data_n;
  logic       user_q, user_n;
  logic       last_q, last_n;
  logic [3:0] rxd_n;
  logic       dv_n, er_n, tready_n, underflow_n;
  logic       accept;

  assign accept = s_axis_tvalid & s_axis_tready;

`ifdef MII_PHY_RX_GEN_FCS_EN
  logic [31:0] crc, crc_n, crc_in, crc_calc;
  logic [31:0] fcs_sr, fcs_n;
  logic [2:0]  fcnt, fcnt_n;

  // The first byte of a frame folds into a freshly initialised CRC.
  assign crc_in = (state == IDLE) ? CRC_INIT : crc;

  eth_crc32_byte u_crc (
    .crc      (crc_in),
    .data     (s_axis_tdata),
    .crc_next (crc_calc)
  );
`endif

  always_comb begin
    state_n     = state;
    half_n      = half;
    pcnt_n      = pcnt;
    icnt_n      = icnt;
    data_n      = data_q;
    user_n      = user_q;
    last_n      = last_q;
    rxd_n       = 4'h0;
    dv_n        = 1'b0;
    er_n        = 1'b0;
    tready_n    = 1'b0;
    underflow_n = 1'b0;
`ifdef MII_PHY_RX_GEN_FCS_EN
    crc_n       = crc;
    fcs_n       = fcs_sr;
    fcnt_n      = fcnt;
`endif
    case (state)
      IDLE: begin
        tready_n = 1'b1;
        if (accept) begin
          data_n   = s_axis_tdata;
          user_n   = s_axis_tuser;
          last_n   = s_axis_tlast;
          state_n  = PREAMBLE;
          pcnt_n   = PRE_LOAD;
          rxd_n    = PREAMBLE_BYTE[3:0];
          dv_n     = 1'b1;
          tready_n = 1'b0;
`ifdef MII_PHY_RX_GEN_FCS_EN
          crc_n    = crc_calc;
`endif
        end
      end
      PREAMBLE: begin
        dv_n = 1'b1;
        if (pcnt == 5'd0) begin
          state_n = SFD;
          half_n  = 1'b0;
          rxd_n   = SFD_BYTE[3:0];
        end else begin
          pcnt_n = pcnt - 5'd1;
          rxd_n  = PREAMBLE_BYTE[3:0];
        end
      end
      SFD: begin
        dv_n = 1'b1;
        if (!half) begin
          half_n = 1'b1;
          rxd_n  = SFD_BYTE[7:4];
        end else begin
          state_n = DATA;
          half_n  = 1'b0;
          rxd_n   = data_q[3:0];
          er_n    = user_q;
        end
      end
      DATA: begin
        dv_n = 1'b1;
        if (!half) begin
          half_n   = 1'b1;
          rxd_n    = data_q[7:4];
          er_n     = user_q;
          tready_n = !last_q;
        end else if (last_q) begin
`ifdef MII_PHY_RX_GEN_FCS_EN
          state_n = FCS;
          rxd_n   = ~crc[3:0];
          fcs_n   = ~crc >> 4;
          fcnt_n  = 3'd0;
`else
          state_n = IFG;
          icnt_n  = IFG_LOAD;
          dv_n    = 1'b0;
`endif
        end else if (accept) begin
          data_n = s_axis_tdata;
          user_n = s_axis_tuser;
          last_n = s_axis_tlast;
          half_n = 1'b0;
          rxd_n  = s_axis_tdata[3:0];
          er_n   = s_axis_tuser;
`ifdef MII_PHY_RX_GEN_FCS_EN
          crc_n  = crc_calc;
`endif
        end else begin
          // Source starved mid-frame: poison the frame with one error nibble.
          underflow_n = 1'b1;
          er_n        = 1'b1;
          state_n     = DROP;
          tready_n    = 1'b1;
        end
      end
      DROP: begin
        if (accept && s_axis_tlast) begin
          state_n = IFG;
          icnt_n  = IFG_LOAD;
        end else begin
          tready_n = 1'b1;
        end
      end
`ifdef MII_PHY_RX_GEN_FCS_EN
      FCS: begin
        if (fcnt == 3'd7) begin
          state_n = IFG;
          icnt_n  = IFG_LOAD;
        end else begin
          dv_n   = 1'b1;
          fcnt_n = fcnt + 3'd1;
          rxd_n  = fcs_sr[3:0];
          fcs_n  = fcs_sr >> 4;
        end
      end
`endif
      IFG: begin
        // The accepting IDLE cycle is the last low-dv cycle of the gap.
        if (icnt <= 8'd1) begin
          state_n  = IDLE;
          tready_n = 1'b1;
        end else begin
          icnt_n = icnt - 8'd1;
        end
      end
      default: begin
        state_n  = IDLE;
        tready_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      half          <= 1'b0;
      pcnt          <= '0;
      icnt          <= '0;
      data_q        <= '0;
      user_q        <= 1'b0;
      last_q        <= 1'b0;
      mii_rxd       <= '0;
      mii_rx_dv     <= 1'b0;
      mii_rx_er     <= 1'b0;
      s_axis_tready <= 1'b0;
      busy          <= 1'b0;
      underflow     <= 1'b0;
`ifdef MII_PHY_RX_GEN_FCS_EN
      crc           <= CRC_INIT;
      fcs_sr        <= '0;
      fcnt          <= '0;
`endif
    end else begin
      state         <= state_n;
      half          <= half_n;
      pcnt          <= pcnt_n;
      icnt          <= icnt_n;
      data_q        <= data_n;
      user_q        <= user_n;
      last_q        <= last_n;
      mii_rxd       <= rxd_n;
      mii_rx_dv     <= dv_n;
      mii_rx_er     <= er_n;
      s_axis_tready <= tready_n;
      busy          <= (state_n != IDLE);
      underflow     <= underflow_n;
`ifdef MII_PHY_RX_GEN_FCS_EN
      crc           <= crc_n;
      fcs_sr        <= fcs_n;
      fcnt          <= fcnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_mii_phy_rx_gen.sv
// Directed bench for mii_phy_rx_gen; expectations follow MII_PHY_RX_GEN_FCS_EN.
module tb_mii_phy_rx_gen;
  import mii_phy_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;
  logic       s_axis_tuser;
  logic [3:0] mii_rxd;
  logic       mii_rx_dv;
  logic       mii_rx_er;
  logic       busy;
  logic       underflow;
  state_t     state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] data;
    logic       user;
    logic       last;
    int         gap;
  } beat_t;

  beat_t src_q[$];
  // {tready, fire, underflow, dv, er, rxd[3:0]} sampled every falling edge
  logic [8:0] cap_q[$];

`ifdef MII_PHY_RX_GEN_FCS_EN
  localparam int FCS_NIB = 8;
`else
  localparam int FCS_NIB = 0;
`endif

  mii_phy_rx_gen dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .mii_rxd       (mii_rxd),
    .mii_rx_dv     (mii_rx_dv),
    .mii_rx_er     (mii_rx_er),
    .busy          (busy),
    .underflow     (underflow),
    .state         (state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(negedge clk)
    cap_q.push_back({s_axis_tready, s_axis_tvalid & s_axis_tready, underflow,
                     mii_rx_dv, mii_rx_er, mii_rxd});

  // source driver: presents src_q head, honouring per-beat idle gaps
  initial begin
    bit    fire;
    beat_t b;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    forever begin
      @(negedge clk);
      fire = s_axis_tvalid && s_axis_tready;
      @(posedge clk);
      #1;
      if (fire && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0 && src_q[0].gap > 0) begin
        b = src_q[0];
        b.gap = b.gap - 1;
        src_q[0] = b;
        s_axis_tvalid = 1'b0;
      end else if (src_q.size() > 0) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = src_q[0].data;
        s_axis_tuser  = src_q[0].user;
        s_axis_tlast  = src_q[0].last;
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
      end
    end
  end

  task automatic push_beat(input logic [7:0] d, input logic u, input logic l, input int g);
    beat_t b;
    b.data = d;
    b.user = u;
    b.last = l;
    b.gap  = g;
    src_q.push_back(b);
  endtask

  task automatic start_capture;
    @(posedge clk);
    #2;
    cap_q.delete();
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    bit seen = 0;
    ok = 0;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      if (busy) seen = 1;
      if (seen && !busy && src_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (mii_rx_dv !== 1'b0) begin failures++; $display("FAIL reset_dv: got %b expected 0", mii_rx_dv); end
    checks++; if (mii_rxd !== 4'h0) begin failures++; $display("FAIL reset_rxd: got %h expected 0", mii_rxd); end
    checks++; if (mii_rx_er !== 1'b0) begin failures++; $display("FAIL reset_er: got %b expected 0", mii_rx_er); end
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL reset_tready: got %b expected 0", s_axis_tready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
    checks++; if (state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", state, IDLE); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL idle_tready: got %b expected 1", s_axis_tready); end
  endtask

  task automatic test_frame;
    logic [3:0] exp_n[$];
    logic [3:0] act_n[$];
    logic [7:0] b;
    logic [3:0] fcs_exp [8];
    int first_dv = -1, last_dv = -1, first_fire = -1, er_cnt = 0;
    bit ok;
    fcs_exp = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
    start_capture();
    for (int i = 0; i < 9; i++) push_beat(8'(8'h31 + i), 1'b0, (i == 8), 0);
    wait_done(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL frame_timeout: got busy=%b expected idle", busy); end
    for (int i = 0; i < 14; i++) exp_n.push_back(4'h5);
    exp_n.push_back(4'h5);
    exp_n.push_back(4'hD);
    for (int i = 0; i < 9; i++) begin
      b = 8'(8'h31 + i);
      exp_n.push_back(b[3:0]);
      exp_n.push_back(b[7:4]);
    end
    for (int i = 0; i < FCS_NIB; i++) exp_n.push_back(fcs_exp[i]);
    for (int i = 0; i < cap_q.size(); i++) begin
      if (cap_q[i][7] && first_fire < 0) first_fire = i;
      if (cap_q[i][5]) begin
        if (first_dv < 0) first_dv = i;
        last_dv = i;
        act_n.push_back(cap_q[i][3:0]);
        if (cap_q[i][4]) er_cnt++;
      end
    end
    checks++; if (first_dv != first_fire + 1) begin failures++; $display("FAIL frame_dv_latency: got dv at %0d expected %0d", first_dv, first_fire + 1); end
    checks++; if (act_n.size() != 34 + FCS_NIB) begin failures++; $display("FAIL frame_dv_count: got %0d expected %0d", act_n.size(), 34 + FCS_NIB); end
    checks++; if (last_dv - first_dv + 1 != act_n.size()) begin failures++; $display("FAIL frame_dv_contiguous: got span %0d expected %0d", last_dv - first_dv + 1, act_n.size()); end
    checks++; if (er_cnt != 0) begin failures++; $display("FAIL frame_er: got %0d er cycles expected 0", er_cnt); end
    for (int i = 0; i < exp_n.size() && i < act_n.size(); i++) begin
      checks++;
      if (act_n[i] !== exp_n[i]) begin failures++; $display("FAIL frame_nibble[%0d]: got %h expected %h", i, act_n[i], exp_n[i]); end
    end
    if (last_dv >= 0 && last_dv + 1 < cap_q.size()) begin
      checks++; if (cap_q[last_dv + 1][5] !== 1'b0) begin failures++; $display("FAIL frame_dv_fall: got %b expected 0", cap_q[last_dv + 1][5]); end
    end
  endtask

  task automatic test_back_to_back;
    int rs[$], re[$];
    logic cur, prev;
    int low_rxd_bad = 0;
    bit ok;
    logic [3:0] d2 [4];
    d2 = '{4'h3, 4'hC, 4'h4, 4'hD};
    start_capture();
    push_beat(8'hA1, 1'b0, 1'b0, 0);
    push_beat(8'hB2, 1'b0, 1'b1, 0);
    push_beat(8'hC3, 1'b0, 1'b0, 0);
    push_beat(8'hD4, 1'b0, 1'b1, 0);
    wait_done(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout: got busy=%b expected idle", busy); end
    for (int i = 0; i < cap_q.size(); i++) begin
      cur  = cap_q[i][5];
      prev = (i > 0) ? cap_q[i - 1][5] : 1'b0;
      if (cur && !prev) rs.push_back(i);
      if (!cur && prev) re.push_back(i - 1);
    end
    checks++;
    if (rs.size() != 2 || re.size() != 2) begin
      failures++; $display("FAIL b2b_runs: got %0d/%0d dv runs expected 2/2", rs.size(), re.size());
    end else begin
      checks++; if (rs[1] - re[0] - 1 != 24) begin failures++; $display("FAIL b2b_gap: got %0d expected 24", rs[1] - re[0] - 1); end
      checks++; if (re[0] - rs[0] + 1 != 20 + FCS_NIB) begin failures++; $display("FAIL b2b_len1: got %0d expected %0d", re[0] - rs[0] + 1, 20 + FCS_NIB); end
      checks++; if (re[1] - rs[1] + 1 != 20 + FCS_NIB) begin failures++; $display("FAIL b2b_len2: got %0d expected %0d", re[1] - rs[1] + 1, 20 + FCS_NIB); end
      checks++; if (cap_q[rs[1] - 1][7] !== 1'b1) begin failures++; $display("FAIL b2b_accept: got %b expected 1", cap_q[rs[1] - 1][7]); end
      checks++; if (cap_q[rs[1] - 2][8] !== 1'b0) begin failures++; $display("FAIL b2b_first_idle: got %b expected 0", cap_q[rs[1] - 2][8]); end
      for (int i = re[0] + 1; i < rs[1]; i++) if (cap_q[i][3:0] != 4'h0) low_rxd_bad++;
      checks++; if (low_rxd_bad != 0) begin failures++; $display("FAIL b2b_gap_rxd: got %0d nonzero expected 0", low_rxd_bad); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cap_q[rs[1] + 16 + i][3:0] !== d2[i]) begin failures++; $display("FAIL b2b_data2[%0d]: got %h expected %h", i, cap_q[rs[1] + 16 + i][3:0], d2[i]); end
      end
    end
  endtask

  task automatic test_underflow;
    int first_dv = -1, last_dv = -1, dv_cnt = 0, uf_cnt = 0, uf_idx = -1, er_cnt = 0;
    bit ok;
    logic [3:0] dexp [4];
    dexp = '{4'h1, 4'h1, 4'h2, 4'h2};
    start_capture();
    push_beat(8'h11, 1'b0, 1'b0, 0);
    push_beat(8'h22, 1'b0, 1'b0, 0);
    push_beat(8'h33, 1'b0, 1'b0, 10);
    push_beat(8'h44, 1'b0, 1'b1, 0);
    wait_done(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL uf_timeout: got busy=%b expected idle", busy); end
    for (int i = 0; i < cap_q.size(); i++) begin
      if (cap_q[i][6]) begin uf_cnt++; uf_idx = i; end
      if (cap_q[i][5]) begin
        if (first_dv < 0) first_dv = i;
        last_dv = i;
        dv_cnt++;
        if (cap_q[i][4]) er_cnt++;
      end
    end
    checks++; if (uf_cnt != 1) begin failures++; $display("FAIL uf_pulses: got %0d expected 1", uf_cnt); end
    checks++; if (dv_cnt != 21) begin failures++; $display("FAIL uf_dv_count: got %0d expected 21", dv_cnt); end
    checks++; if (last_dv - first_dv + 1 != dv_cnt) begin failures++; $display("FAIL uf_dv_contiguous: got span %0d expected %0d", last_dv - first_dv + 1, dv_cnt); end
    checks++; if (er_cnt != 1) begin failures++; $display("FAIL uf_er_count: got %0d expected 1", er_cnt); end
    if (last_dv >= 0 && first_dv >= 0) begin
      checks++; if (cap_q[last_dv][4:0] !== 5'b1_0000) begin failures++; $display("FAIL uf_err_nibble: got er/rxd %b expected 10000", cap_q[last_dv][4:0]); end
      checks++; if (uf_idx != last_dv) begin failures++; $display("FAIL uf_align: got %0d expected %0d", uf_idx, last_dv); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cap_q[first_dv + 16 + i][3:0] !== dexp[i]) begin failures++; $display("FAIL uf_data[%0d]: got %h expected %h", i, cap_q[first_dv + 16 + i][3:0], dexp[i]); end
      end
    end
  endtask

  task automatic test_tuser;
    int first_dv = -1, dv_cnt = 0, er_cnt = 0;
    bit ok;
    start_capture();
    push_beat(8'h0A, 1'b0, 1'b0, 0);
    push_beat(8'h0B, 1'b1, 1'b0, 0);
    push_beat(8'h0C, 1'b0, 1'b1, 0);
    wait_done(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL tuser_timeout: got busy=%b expected idle", busy); end
    for (int i = 0; i < cap_q.size(); i++) begin
      if (cap_q[i][5]) begin
        if (first_dv < 0) first_dv = i;
        dv_cnt++;
        if (cap_q[i][4]) er_cnt++;
      end
    end
    checks++; if (dv_cnt != 22 + FCS_NIB) begin failures++; $display("FAIL tuser_dv_count: got %0d expected %0d", dv_cnt, 22 + FCS_NIB); end
    checks++; if (er_cnt != 2) begin failures++; $display("FAIL tuser_er_count: got %0d expected 2", er_cnt); end
    if (first_dv >= 0) begin
      checks++; if (cap_q[first_dv + 18][4] !== 1'b1) begin failures++; $display("FAIL tuser_er_lo: got %b expected 1", cap_q[first_dv + 18][4]); end
      checks++; if (cap_q[first_dv + 19][4] !== 1'b1) begin failures++; $display("FAIL tuser_er_hi: got %b expected 1", cap_q[first_dv + 19][4]); end
      checks++; if (cap_q[first_dv + 18][3:0] !== 4'hB) begin failures++; $display("FAIL tuser_data_lo: got %h expected b", cap_q[first_dv + 18][3:0]); end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [3:0] tail [8];
    logic [3:0] act_n[$];
    bit ok, hit;
`ifdef MII_PHY_RX_GEN_FCS_EN
    tail = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
`else
    tail = '{4'h6, 4'h3, 4'h7, 4'h3, 4'h8, 4'h3, 4'h9, 4'h3};
`endif
    for (int i = 0; i < 6; i++) push_beat(8'(8'h41 + i), 1'b0, (i == 5), 0);
    hit = 0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      if (state == DATA) hit = 1;
    end
    checks++; if (!hit) begin failures++; $display("FAIL rstmid_reach_data: got state %0d expected %0d", state, DATA); end
    #2;
    rst = 1'b1;
    src_q.delete();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    @(negedge clk);
    checks++; if ({mii_rx_dv, mii_rx_er, mii_rxd} !== 6'b0) begin failures++; $display("FAIL rstmid_mii: got %b expected 000000", {mii_rx_dv, mii_rx_er, mii_rxd}); end
    checks++; if ({s_axis_tready, busy, underflow} !== 3'b0) begin failures++; $display("FAIL rstmid_ctrl: got %b expected 000", {s_axis_tready, busy, underflow}); end
    checks++; if (state !== IDLE) begin failures++; $display("FAIL rstmid_state: got %0d expected %0d", state, IDLE); end
    rst = 1'b0;
    start_capture();
    for (int i = 0; i < 9; i++) push_beat(8'(8'h31 + i), 1'b0, (i == 8), 0);
    wait_done(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_timeout: got busy=%b expected idle", busy); end
    for (int i = 0; i < cap_q.size(); i++) if (cap_q[i][5]) act_n.push_back(cap_q[i][3:0]);
    checks++;
    if (act_n.size() != 34 + FCS_NIB) begin
      failures++; $display("FAIL rstmid_dv_count: got %0d expected %0d", act_n.size(), 34 + FCS_NIB);
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (act_n[i] !== ((i == 15) ? 4'hD : 4'h5)) begin failures++; $display("FAIL rstmid_pre[%0d]: got %h expected %h", i, act_n[i], (i == 15) ? 4'hD : 4'h5); end
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (act_n[act_n.size() - 8 + i] !== tail[i]) begin failures++; $display("FAIL rstmid_tail[%0d]: got %h expected %h", i, act_n[act_n.size() - 8 + i], tail[i]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_frame();
    test_back_to_back();
    test_underflow();
    test_tuser();
    test_reset_mid_frame();
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
